// File: rtl/icu_dm_cache.sv
// Direct-mapped instruction cache: ic1 accept / ic2 tag compare, whole-line BIU refill then ic2 replay.
// Optional `ICU_INVALIDATE_EN adds ifu_icu_inv, a flush of all valid bits.
module icu_dm_cache #(
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:3] ifu_icu_addr_ic1,
  output logic        icu_ifu_ack_ic1,
  output logic        icu_ifu_data_valid_ic2,
  output logic [63:0] icu_ifu_data_ic2,
`ifdef ICU_INVALIDATE_EN
  input  logic        ifu_icu_inv,
`endif
  output logic        icu_biu_req,
  output logic [31:3] icu_biu_addr,
  input  logic        biu_icu_ack,
  input  logic        biu_icu_data_valid,
  input  logic        biu_icu_data_last,
  input  logic [63:0] biu_icu_data
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned OFF_W = $clog2(LINE_BEATS);
  localparam int unsigned TAG_W = 29 - IDX_W - OFF_W;
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam int unsigned ENT_W = IDX_W + OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ic2_vld_q;
  logic [31:3]         ic2_addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [63:0]         data_q [NUM_SETS*LINE_BEATS];

  logic [OFF_W-1:0] ic2_off;
  logic [IDX_W-1:0] ic2_idx;
  logic [TAG_W-1:0] ic2_tag;
  logic [ENT_W-1:0] rd_ent_c, wr_ent_c;
  logic             hit_c, miss_c, fill_beat_c, fill_done_c, line_ok_c, beat_wr_c;
  logic             inv_c, inv_flush_c;

  assign ic2_off = ic2_addr_q[3 +: OFF_W];
  assign ic2_idx = ic2_addr_q[3 + OFF_W +: IDX_W];
  assign ic2_tag = ic2_addr_q[31 -: TAG_W];

  assign rd_ent_c = {ic2_idx, ic2_off};
  assign wr_ent_c = {ic2_idx, cnt_q[OFF_W-1:0]};

  assign hit_c  = ic2_vld_q & valid_q[ic2_idx] & (tag_q[ic2_idx] == ic2_tag) & (state_q == ST_IDLE);
  assign miss_c = ic2_vld_q & ~hit_c & (state_q == ST_IDLE);

  // cnt saturates at LINE_BEATS so overrun beats are dropped and a late last cannot validate the line
  assign fill_beat_c = (state_q == ST_FILL) & biu_icu_data_valid;
  assign fill_done_c = fill_beat_c & biu_icu_data_last;
  assign line_ok_c   = fill_done_c & (cnt_q == CNT_W'(LINE_BEATS - 1));
  assign beat_wr_c   = fill_beat_c & (cnt_q != CNT_W'(LINE_BEATS));

`ifdef ICU_INVALIDATE_EN
  logic inv_pend_q;

  assign inv_c       = ifu_icu_inv;
  assign inv_flush_c = inv_pend_q | ifu_icu_inv;

  // invalidate seen during a refill waits until the line is written
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inv_pend_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      inv_pend_q <= 1'b0;
    end else if (ifu_icu_inv) begin
      inv_pend_q <= 1'b1;
    end
  end
`else
  assign inv_c       = 1'b0;
  assign inv_flush_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!inv_c && miss_c)  state_d = ST_REQ;
      ST_REQ:  if (biu_icu_ack)       state_d = ST_FILL;
      ST_FILL: if (fill_done_c)       state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    icu_ifu_ack_ic1        = 1'b0;
    icu_ifu_data_valid_ic2 = 1'b0;
    icu_ifu_data_ic2       = 64'h0;
    icu_biu_req            = 1'b0;
    icu_biu_addr           = '0;
    icu_ifu_ack_ic1        = ifu_icu_req_ic1 & (state_q == ST_IDLE) & ~miss_c & ~inv_c;
    if (hit_c) begin
      icu_ifu_data_valid_ic2 = 1'b1;
      icu_ifu_data_ic2       = data_q[rd_ent_c];
    end
    if (state_q == ST_REQ) begin
      icu_biu_req  = 1'b1;
      icu_biu_addr = {ic2_tag, ic2_idx, OFF_W'(0)};
    end
  end

  // valid bits: drop on refill start, set on a complete line, flush on invalidate
  always_comb begin
    valid_d = valid_q;
    if ((state_q == ST_REQ) && biu_icu_ack) valid_d[ic2_idx] = 1'b0;
    if (line_ok_c)                          valid_d[ic2_idx] = 1'b1;
    if (((state_q == ST_IDLE) && inv_c) || (fill_done_c && inv_flush_c)) valid_d = '0;
  end

  // ic2 stage holds its address across a miss so the lookup replays after the fill
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ic2_vld_q  <= 1'b0;
      ic2_addr_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (inv_c) begin
        ic2_vld_q <= 1'b0;
      end else if (icu_ifu_ack_ic1) begin
        ic2_vld_q  <= 1'b1;
        ic2_addr_q <= ifu_icu_addr_ic1;
      end else if (!miss_c) begin
        ic2_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if ((state_q == ST_REQ) && biu_icu_ack) begin
      cnt_q <= '0;
    end else if (beat_wr_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr_c) data_q[wr_ent_c] <= biu_icu_data;
    if (line_ok_c) tag_q[ic2_idx]   <= ic2_tag;
  end

endmodule

// File: tb/tb_icu_dm_cache.sv
// Directed bench for icu_dm_cache (16 sets, 4-beat lines): a line-level cache model predicts
// every ic1 ack, ic2 return and BIU request; literal checks at key points pin the model.
module tb_icu_dm_cache;

  localparam int unsigned NUM_SETS   = 16;
  localparam int unsigned LINE_BEATS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic [31:3] addr;
  logic        ack, dv;
  logic [63:0] rdata;
  logic        breq;
  logic [31:3] baddr;
  logic        back, bdv, blast;
  logic [63:0] bdata;
`ifdef ICU_INVALIDATE_EN
  logic        inv;
`endif

  always #5 clk = ~clk;

  icu_dm_cache #(.NUM_SETS(NUM_SETS), .LINE_BEATS(LINE_BEATS)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .ifu_icu_req_ic1       (req),
    .ifu_icu_addr_ic1      (addr),
    .icu_ifu_ack_ic1       (ack),
    .icu_ifu_data_valid_ic2(dv),
    .icu_ifu_data_ic2      (rdata),
`ifdef ICU_INVALIDATE_EN
    .ifu_icu_inv           (inv),
`endif
    .icu_biu_req           (breq),
    .icu_biu_addr          (baddr),
    .biu_icu_ack           (back),
    .biu_icu_data_valid    (bdv),
    .biu_icu_data_last     (blast),
    .biu_icu_data          (bdata)
  );

  // line-level model of the cache contents
  bit          m_valid [NUM_SETS];
  int unsigned m_tag   [NUM_SETS];
  logic [63:0] m_data  [NUM_SETS][LINE_BEATS];
  logic [63:0] beats   [LINE_BEATS];

  bit          e_ack, e_dv, e_breq;
  logic [63:0] e_data;
  logic [31:3] e_baddr;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;

  function automatic int unsigned a_off(input logic [31:3] a);
    return 32'(a) % LINE_BEATS;
  endfunction
  function automatic int unsigned a_idx(input logic [31:3] a);
    return (32'(a) / LINE_BEATS) % NUM_SETS;
  endfunction
  function automatic int unsigned a_tag(input logic [31:3] a);
    return 32'(a) / (LINE_BEATS * NUM_SETS);
  endfunction
  function automatic logic [31:3] a_line(input logic [31:3] a);
    return 29'(32'(a) - a_off(a));
  endfunction
  function automatic bit m_hit(input logic [31:3] a);
    return m_valid[a_idx(a)] && (m_tag[a_idx(a)] == a_tag(a));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack_ic1",        64'(ack),   64'(e_ack));
      chk("data_valid_ic2", 64'(dv),    64'(e_dv));
      chk("data_ic2",       rdata,      e_dv ? e_data : 64'h0);
      chk("biu_req",        64'(breq),  64'(e_breq));
      chk("biu_addr",       64'(baddr), e_breq ? 64'(e_baddr) : 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3);
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
  endtask

  task automatic set_ret(input logic [31:3] a);
    e_dv   = m_hit(a);
    e_data = m_data[a_idx(a)][a_off(a)];
  endtask

  // cycle after an ic2 lookup: a miss raises the line request
  task automatic post(input logic [31:3] a, input bit hit);
    tick();
    e_dv = 1'b0;
    if (!hit) begin
      e_breq  = 1'b1;
      e_baddr = a_line(a);
    end
  endtask

  task automatic access(input logic [31:3] a, output bit hit);
    req = 1'b1; addr = a; e_ack = 1'b1; e_dv = 1'b0; e_breq = 1'b0;
    tick();
    req = 1'b0; e_ack = 1'b0;
    set_ret(a);
    hit = e_dv;
    post(a, hit);
  endtask

  // BIU side of a refill; ic1 keeps requesting to show nothing is accepted outside IDLE
  task automatic serve(input logic [31:3] a, input int ack_dly, input int n, input int last_at,
                       input int rst_at, output bit hit);
    int unsigned idx;
    bit          dead;
    idx  = a_idx(a);
    dead = 1'b0;
    req = 1'b1; addr = a + 29'd1; e_ack = 1'b0;
    for (int k = 0; k < ack_dly; k++) tick();
    back = 1'b1;
    tick();
    back = 1'b0; e_breq = 1'b0;
    m_valid[idx] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        bdv = 1'b0; blast = 1'b0;
        tick();
      end
      if (i == rst_at) begin
        resetn = 1'b0; bdv = 1'b0; blast = 1'b0; req = 1'b0; dead = 1'b1;
        for (int s = 0; s < NUM_SETS; s++) m_valid[s] = 1'b0;
        tick();
        resetn = 1'b1;
      end
      bdv = 1'b1; blast = (i == last_at); bdata = beats[i];
      if (!dead) begin
        m_data[idx][i] = beats[i];
        if ((i == last_at) && (i == LINE_BEATS - 1)) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = a_tag(a);
        end
      end
      tick();
    end
    bdv = 1'b0; blast = 1'b0; req = 1'b0;
    if (dead) begin
      hit  = 1'b0;
      e_dv = 1'b0;
    end else begin
      set_ret(a);
      hit = e_dv;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    bit h;
    resetn = 1'b0; req = 1'b0; addr = '0; back = 1'b0; bdv = 1'b0; blast = 1'b0; bdata = '0;
`ifdef ICU_INVALIDATE_EN
    inv = 1'b0;
`endif
    e_ack = 1'b0; e_dv = 1'b0; e_breq = 1'b0; e_data = '0; e_baddr = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      m_valid[s] = 1'b0;
      m_tag[s]   = 0;
      for (int b = 0; b < LINE_BEATS; b++) m_data[s][b] = 64'h0;
    end
    chk_en = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // cold miss, refill, replay returns beat 0
    set_beats(64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD);
    access(29'h2020, h);
    @(negedge clk); chk("t1_refill_addr", 64'(baddr), 64'h2020);
    serve(29'h2020, 1, 4, 3, -1, h);
    @(negedge clk); chk("t1_replay_valid", 64'(dv), 64'h1);
    chk("t1_replay_data", rdata, 64'hAAAAAAAAAAAAAAAA);
    post(29'h2020, h);

    // back-to-back hits, one beat per cycle
    req = 1'b1; addr = 29'h2021; e_ack = 1'b1; e_dv = 1'b0; e_breq = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      set_ret(29'h2020 + 29'(k - 1));
      if (k < 4) addr = 29'h2020 + 29'(k);
      else begin
        req = 1'b0; e_ack = 1'b0;
      end
    end
    @(negedge clk); chk("t2_last_hit_data", rdata, 64'hDDDDDDDDDDDDDDDD);
    tick();
    e_dv = 1'b0;

    // conflict in set 8 evicts, then the old line misses again
    set_beats(64'h1111111111111111, 64'h1111111111111111, 64'h1111111111111111, 64'h1111111111111111);
    access(29'h2060, h);
    @(negedge clk); chk("t3_conflict_addr", 64'(baddr), 64'h2060);
    serve(29'h2060, 0, 4, 3, -1, h);
    @(negedge clk); chk("t3_conflict_data", rdata, 64'h1111111111111111);
    post(29'h2060, h);
    set_beats(64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD);
    access(29'h2020, h);
    @(negedge clk); chk("t3_evicted_miss", 64'(breq), 64'h1);
    chk("t3_evicted_addr", 64'(baddr), 64'h2020);
    serve(29'h2020, 2, 4, 3, -1, h);
    post(29'h2020, h);

    // early last: line stays invalid, replay misses and refetches
    set_beats(64'hE0E0E0E0E0E0E0E0, 64'hE1E1E1E1E1E1E1E1, 64'hE2E2E2E2E2E2E2E2, 64'hE3E3E3E3E3E3E3E3);
    access(29'h2040, h);
    serve(29'h2040, 0, 2, 1, -1, h);
    @(negedge clk); chk("t4_early_last_no_data", 64'(dv), 64'h0);
    post(29'h2040, h);
    @(negedge clk); chk("t4_second_req_addr", 64'(baddr), 64'h2040);
    serve(29'h2040, 0, 4, 3, -1, h);
    @(negedge clk); chk("t4_full_fill_beat0", rdata, 64'hE0E0E0E0E0E0E0E0);
    post(29'h2040, h);

    // reset in the middle of a fill; trailing beats are ignored
    set_beats(64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888);
    access(29'h2060, h);
    serve(29'h2060, 0, 4, 3, 2, h);
    @(negedge clk); chk("t5_post_reset_req", 64'(breq), 64'h0);
    chk("t5_post_reset_data", rdata, 64'h0);
    set_beats(64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD);
    access(29'h2020, h);
    @(negedge clk); chk("t5_miss_after_reset", 64'(baddr), 64'h2020);
    serve(29'h2020, 1, 4, 3, -1, h);
    @(negedge clk); chk("t5_refill_data", rdata, 64'hAAAAAAAAAAAAAAAA);
    post(29'h2020, h);

`ifdef ICU_INVALIDATE_EN
    // invalidate in IDLE blocks the ack and flushes every line
    inv = 1'b1; req = 1'b1; addr = 29'h2021; e_ack = 1'b0;
    tick();
    inv = 1'b0; req = 1'b0; e_dv = 1'b0;
    for (int s = 0; s < NUM_SETS; s++) m_valid[s] = 1'b0;
    access(29'h2021, h);
    @(negedge clk); chk("t6_inv_refetch_addr", 64'(baddr), 64'h2020);
    serve(29'h2021, 0, 4, 3, -1, h);
    @(negedge clk); chk("t6_inv_refill_data", rdata, 64'hBBBBBBBBBBBBBBBB);
    post(29'h2021, h);
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
